// File: rtl/core_run_ctrl_if.sv
// ---------------------------------------------------------------------------
// core_run_ctrl_if
// Purpose : bundles the run/debug sequencer's control and status signals so
//           the sequencer and the core top (or a testbench) share one port.
// Modports:
//   master - drives start/halt_req/step_req, breakpoint setup, pc and instr;
//            observes the gating and status outputs.
//   slave  - the sequencer side (core_run_ctrl).
// Signals :
//   start, halt_req, step_req  run/halt/step requests
//   bp_en, bp_addr             breakpoint compare enable and address
//   pc, instr                  current PC and fetched instruction
//   pc_en, wr_en               PC-load and architectural write gates
//   state, halted, halt_cause  sequencer status
//   retired_cnt                instructions retired since reset
// ---------------------------------------------------------------------------
interface core_run_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic             halt_req;
  logic             step_req;
  logic             bp_en;
  logic [31:0]      bp_addr;
  logic [31:0]      pc;
  logic [31:0]      instr;
  logic             pc_en;
  logic             wr_en;
  logic [1:0]       state;
  logic             halted;
  logic [1:0]       halt_cause;
  logic [CNT_W-1:0] retired_cnt;

  modport master (
    output start, halt_req, step_req, bp_en, bp_addr, pc, instr,
    input  pc_en, wr_en, state, halted, halt_cause, retired_cnt
  );

  modport slave (
    input  start, halt_req, step_req, bp_en, bp_addr, pc, instr,
    output pc_en, wr_en, state, halted, halt_cause, retired_cnt
  );
endinterface

// File: rtl/core_run_ctrl.sv
// ---------------------------------------------------------------------------
// core_run_ctrl
// Purpose : run/debug sequencer for the single-cycle RISC-V core. Gates the PC
//           update and the register-file/data-memory write enables so the core
//           can idle, free-run, halt on request, halt on a breakpoint or ECALL,
//           and single-step.
// Ports   :
//   clk    - core clock, all state updates on the rising edge
//   reset  - synchronous active-high reset
//   bus    - core_run_ctrl_if.slave (requests, breakpoint, pc/instr in;
//            pc_en/wr_en gates, state, halted, halt_cause, retired_cnt out)
// Config  : define CORE_RUN_CTRL_RETIRE_CNT_EN to build the retired-instruction
//           counter; without it retired_cnt is tied to zero and no counter
//           flops exist.
// ---------------------------------------------------------------------------
module core_run_ctrl #(
  parameter int          CNT_W      = 32,
  parameter logic [31:0] ECALL_WORD = 32'h0000_0073
) (
  input logic           clk,
  input logic           reset,
  core_run_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10,
    HALT = 2'b11
  } state_e;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_EXT   = 2'b01;
  localparam logic [1:0] CAUSE_BP    = 2'b10;
  localparam logic [1:0] CAUSE_ECALL = 2'b11;

  state_e           state_q;
  logic             halted_q;
  logic [1:0]       haltCause_q;
  logic             skipBp_q;
  logic             bpHit;
  logic             ecallHit;
  logic             pcEn;
  logic [CNT_W-1:0] retiredCnt;

  // Hit detection and execution gating. skipBp_q masks the breakpoint for the
  // first cycle after a resume so the core can step off the halting address.
  // A STEP cycle always executes, whatever the instruction or address.
  always_comb begin
    bpHit    = bus.bp_en & (bus.pc == bus.bp_addr) & ~skipBp_q;
    ecallHit = (bus.instr == ECALL_WORD);
    pcEn     = ((state_q == RUN) & ~bpHit & ~ecallHit & ~bus.halt_req)
             | (state_q == STEP);
  end

  // Sequencer FSM. halted and halt_cause are registered alongside the state
  // so they change on the same edge. In RUN the halt sources are checked
  // external request first, then ECALL, then breakpoint.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      halted_q    <= 1'b0;
      haltCause_q <= CAUSE_NONE;
      skipBp_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          skipBp_q <= 1'b0;
          if (bus.halt_req) begin
            state_q     <= HALT;
            halted_q    <= 1'b1;
            haltCause_q <= CAUSE_EXT;
          end else if (ecallHit) begin
            state_q     <= HALT;
            halted_q    <= 1'b1;
            haltCause_q <= CAUSE_ECALL;
          end else if (bpHit) begin
            state_q     <= HALT;
            halted_q    <= 1'b1;
            haltCause_q <= CAUSE_BP;
          end
        end
        HALT: begin
          if (bus.start) begin
            state_q     <= RUN;
            halted_q    <= 1'b0;
            haltCause_q <= CAUSE_NONE;
            skipBp_q    <= 1'b1;
          end else if (bus.step_req) begin
            state_q  <= STEP;
            halted_q <= 1'b0;
          end
        end
        STEP: begin
          state_q  <= HALT;
          halted_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef CORE_RUN_CTRL_RETIRE_CNT_EN
  logic [CNT_W-1:0] retiredCnt_q;

  // Retired-instruction counter: one count per executed instruction, wrapping
  // silently at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      retiredCnt_q <= '0;
    end else if (pcEn) begin
      retiredCnt_q <= retiredCnt_q + 1'b1;
    end
  end

  assign retiredCnt = retiredCnt_q;
`else
  assign retiredCnt = '0;
`endif

  assign bus.pc_en       = pcEn;
  assign bus.wr_en       = pcEn;
  assign bus.state       = state_q;
  assign bus.halted      = halted_q;
  assign bus.halt_cause  = haltCause_q;
  assign bus.retired_cnt = retiredCnt;

endmodule

// File: tb/tb_core_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_core_run_ctrl
// Purpose : directed testbench for core_run_ctrl. A tiny PC counter inside the
//           bench advances by 4 on every edge where pc_en was high, mirroring
//           how the core top uses the gate. Expected values are hand-derived.
// ---------------------------------------------------------------------------
module tb_core_run_ctrl;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  logic        clk;
  logic        reset;
  logic [31:0] pcModel;
  int          checksTotal;
  int          checksPassed;

  core_run_ctrl_if #(.CNT_W(32)) bus ();

  core_run_ctrl #(
    .CNT_W      (32),
    .ECALL_WORD (ECALL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected counter value: the counter only exists when the feature is built.
  function automatic logic [31:0] expCnt(input logic [31:0] n);
`ifdef CORE_RUN_CTRL_RETIRE_CNT_EN
    return n;
`else
    return 32'd0;
`endif
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checksTotal++;
    if (observed === expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Sets the request inputs, then lets combinational outputs settle.
  task automatic applyStimulus(input logic st, input logic hr, input logic sr);
    bus.start    = st;
    bus.halt_req = hr;
    bus.step_req = sr;
    #1;
  endtask

  // Advances one clock edge and updates the bench PC counter the way the core
  // would: cleared by reset, otherwise +4 when pc_en was high at the edge.
  task automatic tick();
    logic en;
    logic rst;
    en  = bus.pc_en;
    rst = reset;
    @(posedge clk);
    #1;
    if (rst)     pcModel = 32'd0;
    else if (en) pcModel = pcModel + 32'd4;
    bus.pc = pcModel;
    #1;
  endtask

  initial begin
    checksTotal  = 0;
    checksPassed = 0;
    pcModel      = 32'd0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.halt_req = 1'b0;
    bus.step_req = 1'b0;
    bus.bp_en    = 1'b0;
    bus.bp_addr  = 32'd0;
    bus.pc       = 32'd0;
    bus.instr    = NOP;

    // Reset state
    tick();
    tick();
    checkOutput("rst_state",  {30'd0, bus.state},      32'd0);
    checkOutput("rst_halted", {31'd0, bus.halted},     32'd0);
    checkOutput("rst_cause",  {30'd0, bus.halt_cause}, 32'd0);
    checkOutput("rst_cnt",    bus.retired_cnt,         32'd0);
    reset = 1'b0;

    // Start and free-run
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("idle_pc_en", {31'd0, bus.pc_en}, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("run_state",    {30'd0, bus.state}, 32'd1);
    checkOutput("run_first_en", {31'd0, bus.pc_en}, 32'd1);
    checkOutput("run_first_we", {31'd0, bus.wr_en}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      checkOutput("run_pc_en", {31'd0, bus.pc_en}, 32'd1);
      tick();
    end
    checkOutput("run10_state", {30'd0, bus.state}, 32'd1);
    checkOutput("run10_cnt",   bus.retired_cnt,    expCnt(32'd10));

    // External halt latency: gate drops in the request cycle, halted next
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("hreq_pc_en",  {31'd0, bus.pc_en},  32'd0);
    checkOutput("hreq_halted", {31'd0, bus.halted}, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("hreq_halted1", {31'd0, bus.halted},     32'd1);
    checkOutput("hreq_state",   {30'd0, bus.state},      32'd3);
    checkOutput("hreq_cause",   {30'd0, bus.halt_cause}, 32'd1);
    checkOutput("hreq_cnt",     bus.retired_cnt,         expCnt(32'd10));

    // Breakpoint at 0x10 and resume, from a fresh reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.bp_en   = 1'b1;
    bus.bp_addr = 32'h0000_0010;
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("bp_pc",      bus.pc,             32'h10);
    checkOutput("bp_hit_en",  {31'd0, bus.pc_en}, 32'd0);
    tick();
    checkOutput("bp_state",   {30'd0, bus.state},      32'd3);
    checkOutput("bp_cause",   {30'd0, bus.halt_cause}, 32'd2);
    checkOutput("bp_pc_held", bus.pc,                  32'h10);
    checkOutput("bp_cnt",     bus.retired_cnt,         expCnt(32'd4));
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("halt_pc_en", {31'd0, bus.pc_en}, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("resume_en",    {31'd0, bus.pc_en},      32'd1);
    checkOutput("resume_cause", {30'd0, bus.halt_cause}, 32'd0);
    checkOutput("resume_hlt",   {31'd0, bus.halted},     32'd0);
    tick();
    checkOutput("resume_state", {30'd0, bus.state}, 32'd1);
    checkOutput("resume_pc",    bus.pc,             32'h14);
    checkOutput("resume_cnt",   bus.retired_cnt,    expCnt(32'd5));
    bus.bp_en = 1'b0;

    // ECALL halt: not executed, counter unchanged
    bus.instr = ECALL;
    #1;
    checkOutput("ecall_en", {31'd0, bus.pc_en}, 32'd0);
    tick();
    bus.instr = NOP;
    #1;
    checkOutput("ecall_state", {30'd0, bus.state},      32'd3);
    checkOutput("ecall_cause", {30'd0, bus.halt_cause}, 32'd3);
    checkOutput("ecall_cnt",   bus.retired_cnt,         expCnt(32'd5));

    // Single step three times; cause is kept
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("step_req_en", {31'd0, bus.pc_en}, 32'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("step_state", {30'd0, bus.state}, 32'd2);
      checkOutput("step_en",    {31'd0, bus.pc_en}, 32'd1);
      tick();
      checkOutput("step_back",  {30'd0, bus.state},      32'd3);
      checkOutput("step_hlt",   {31'd0, bus.halted},     32'd1);
      checkOutput("step_cause", {30'd0, bus.halt_cause}, 32'd3);
    end
    checkOutput("step_cnt", bus.retired_cnt, expCnt(32'd8));
    checkOutput("step_pc",  bus.pc,          32'h20);

    // Simultaneous halt_req and breakpoint: external wins
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    bus.bp_en   = 1'b1;
    bus.bp_addr = 32'h0000_0024;
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("both_en", {31'd0, bus.pc_en}, 32'd0);
    tick();
    bus.bp_en = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("both_cause", {30'd0, bus.halt_cause}, 32'd1);
    checkOutput("both_cnt",   bus.retired_cnt,         expCnt(32'd9));

    // start and step_req together in HALT: start wins
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("ss_state", {30'd0, bus.state}, 32'd1);

    // halt_req held through HALT with start: back to RUN, re-halt, no retire
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("hold_state", {30'd0, bus.state}, 32'd1);
    checkOutput("hold_en",    {31'd0, bus.pc_en}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("hold_halt",  {30'd0, bus.state},      32'd3);
    checkOutput("hold_cause", {30'd0, bus.halt_cause}, 32'd1);
    checkOutput("hold_cnt",   bus.retired_cnt,         expCnt(32'd9));

    // Reset in the middle of a STEP
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("mid_step", {30'd0, bus.state}, 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checkOutput("mrst_state",  {30'd0, bus.state},      32'd0);
    checkOutput("mrst_halted", {31'd0, bus.halted},     32'd0);
    checkOutput("mrst_cause",  {30'd0, bus.halt_cause}, 32'd0);
    checkOutput("mrst_cnt",    bus.retired_cnt,         32'd0);
    checkOutput("mrst_en",     {31'd0, bus.pc_en},      32'd0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
